// File: rtl/mux_select_arbiter.sv
// Four-way round-robin arbiter for a shared 32-bit 4:1 mux/resource pair.
// Grants are held until DONE, requester withdrawal or the MAX_HOLD limit, then a one-cycle turnaround.
module mux_select_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [1:0] SEL,
  output logic [3:0] GNT,
  output logic       VALID,
  output logic       TIMEOUT
);

  localparam int unsigned CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_e;

  state_e        state_q;
  logic [1:0]    sel_q;
  logic [1:0]    last_q;
  logic [3:0]    gnt_q;
  logic          valid_q;
  logic          timeout_q;
  logic [CW-1:0] cnt_q;

  logic          win_valid;
  logic [1:0]    win_idx;
  logic          rel_normal;
  logic          rel_limit;

  // Scan from farthest to nearest offset so the nearest requester after last_q wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last_q;
    for (int unsigned i = 4; i >= 1; i--) begin
      if (REQ[last_q + 2'(i)]) begin
        win_valid = 1'b1;
        win_idx   = last_q + 2'(i);
      end
    end
  end

  always_comb begin
    rel_normal = DONE || !REQ[sel_q];
    rel_limit  = !rel_normal && (cnt_q == HOLD_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'b00;
      last_q    <= 2'd3;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            sel_q   <= win_idx;
            gnt_q   <= 4'b0001 << win_idx;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // last_q is captured on entry to RELEASE; SEL is frozen there so the value is identical.
          if (rel_normal || rel_limit) begin
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= sel_q;
            timeout_q <= rel_limit;
            state_q   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign SEL     = sel_q;
  assign GNT     = gnt_q;
  assign VALID   = valid_q;
  assign TIMEOUT = timeout_q;

  a_gnt_onehot0: assert property (@(posedge CLK) $onehot0(GNT));
  a_valid_gnt:   assert property (@(posedge CLK) VALID == (|GNT));
  a_sel_gnt:     assert property (@(posedge CLK) !VALID || GNT[SEL]);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Randomised and directed bench for mux_select_arbiter against a transaction-level model.
module tb_mux_select_arbiter;

  localparam int MAX_HOLD = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic       DONE = 1'b0;
  logic [1:0] SEL;
  logic [3:0] GNT;
  logic       VALID;
  logic       TIMEOUT;

  int vectors = 0;
  int miscompares = 0;

  mux_select_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
    .SEL(SEL), .GNT(GNT), .VALID(VALID), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Model: owner = granted index or -1, age = edges since the grant, turn = turnaround cycle pending.
  int m_owner = -1;
  int m_age   = 0;
  int m_last  = 3;
  int m_sel   = 0;
  bit m_to    = 1'b0;
  bit m_turn  = 1'b0;

  task automatic model_step(input logic [3:0] req, input logic done, input logic rst);
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = 3; m_sel = 0; m_to = 1'b0; m_turn = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_age++;
      if (done || !req[m_owner] || m_age == MAX_HOLD) begin
        m_to    = !(done || !req[m_owner]);
        m_last  = m_owner;
        m_owner = -1;
        m_turn  = 1'b1;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
      end
      m_sel = m_owner;
      m_age = 0;
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    s = 2'(m_sel);
    return {s, g, (m_owner >= 0), m_to};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step(REQ, DONE, RST);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 4'b1111; DONE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== 8'h00) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h expected 00", c, {SEL, GNT, VALID, TIMEOUT});
      end
    end
    RST = 1'b0; REQ = 4'b0000; DONE = 1'b0;
  endtask

  task automatic test_done_in_idle();
    for (int c = 0; c < 8; c++) begin
      DONE = c[0];
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== 8'h00) begin
        miscompares++;
        $display("FAIL done_idle c%0d: got %h expected 00", c, {SEL, GNT, VALID, TIMEOUT});
      end
    end
    DONE = 1'b0;
  endtask

  task automatic test_round_robin();
    int nstart = 0;
    int last_start = -1;
    logic prev_v = 1'b0;
    logic [3:0] eg;
    RST = 1'b1; tick(); RST = 1'b0;
    REQ = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      DONE = (m_owner >= 0 && m_age == 1);
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr_model c%0d: got %h expected %h", c, {SEL, GNT, VALID, TIMEOUT}, exp_vec());
      end
      if (VALID && !prev_v) begin
        eg = 4'b0001 << (nstart % 4);
        vectors++;
        if (GNT !== eg) begin
          miscompares++;
          $display("FAIL rr_order start%0d: got %b expected %b", nstart, GNT, eg);
        end
        if (last_start >= 0) begin
          vectors++;
          if (c - last_start != 4) begin
            miscompares++;
            $display("FAIL rr_spacing start%0d: got %0d expected 4", nstart, c - last_start);
          end
        end
        last_start = c;
        nstart++;
      end
      prev_v = VALID;
    end
    vectors++;
    if (nstart != 5) begin
      miscompares++;
      $display("FAIL rr_count: got %0d expected 5", nstart);
    end
    DONE = 1'b0; REQ = 4'b0000;
  endtask

  task automatic test_timeout();
    int held = 0;
    int first_zero = -1;
    int regrant = -1;
    logic to_at = 1'b0;
    RST = 1'b1; tick(); RST = 1'b0;
    REQ = 4'b0100; DONE = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== exp_vec()) begin
        miscompares++;
        $display("FAIL to_model c%0d: got %h expected %h", c, {SEL, GNT, VALID, TIMEOUT}, exp_vec());
      end
      if (first_zero < 0 && GNT == 4'b0100) held++;
      else if (first_zero < 0 && held > 0) begin
        first_zero = c;
        to_at = TIMEOUT;
      end else if (first_zero >= 0 && regrant < 0 && GNT == 4'b0100) regrant = c;
    end
    vectors++;
    if (held != MAX_HOLD) begin
      miscompares++;
      $display("FAIL to_held: got %0d expected %0d", held, MAX_HOLD);
    end
    vectors++;
    if (to_at !== 1'b1) begin
      miscompares++;
      $display("FAIL to_pulse: got %b expected 1", to_at);
    end
    vectors++;
    if (regrant - first_zero != 2) begin
      miscompares++;
      $display("FAIL to_regrant: got %0d expected 2", regrant - first_zero);
    end
    REQ = 4'b0000;
  endtask

  task automatic test_withdraw();
    logic [3:0] reqs [6] = '{4'b0010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
    RST = 1'b1; tick(); RST = 1'b0; DONE = 1'b0;
    for (int c = 0; c < 6; c++) begin
      REQ = reqs[c];
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== exp_vec()) begin
        miscompares++;
        $display("FAIL wd_model c%0d: got %h expected %h", c, {SEL, GNT, VALID, TIMEOUT}, exp_vec());
      end
      if (c == 3) begin
        vectors++;
        if ({SEL, GNT, TIMEOUT} !== {2'b01, 4'b0000, 1'b0}) begin
          miscompares++;
          $display("FAIL wd_release: got sel=%b gnt=%b to=%b expected sel=01 gnt=0000 to=0", SEL, GNT, TIMEOUT);
        end
      end
      if (c == 5) begin
        vectors++;
        if ({SEL, GNT} !== {2'b11, 4'b1000}) begin
          miscompares++;
          $display("FAIL wd_next: got sel=%b gnt=%b expected sel=11 gnt=1000", SEL, GNT);
        end
      end
    end
    REQ = 4'b0000;
  endtask

  task automatic test_done_at_limit();
    bit hit = 1'b0;
    RST = 1'b1; tick(); RST = 1'b0;
    REQ = 4'b0001;
    for (int c = 0; c < 21; c++) begin
      DONE = (m_owner >= 0 && m_age == MAX_HOLD - 1);
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== exp_vec()) begin
        miscompares++;
        $display("FAIL lim_model c%0d: got %h expected %h", c, {SEL, GNT, VALID, TIMEOUT}, exp_vec());
      end
      if (DONE) begin
        hit = 1'b1;
        vectors++;
        if ({GNT, TIMEOUT} !== 5'b00000) begin
          miscompares++;
          $display("FAIL lim_done: got gnt=%b to=%b expected gnt=0000 to=0", GNT, TIMEOUT);
        end
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL lim_reached: got 0 expected 1");
    end
    DONE = 1'b0; REQ = 4'b0000;
  endtask

  task automatic test_reset_mid_grant();
    logic [3:0] reqs [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101};
    logic       rsts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    RST = 1'b1; tick(); RST = 1'b0; DONE = 1'b0;
    for (int c = 0; c < 5; c++) begin
      REQ = reqs[c]; RST = rsts[c];
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== exp_vec()) begin
        miscompares++;
        $display("FAIL rst_model c%0d: got %h expected %h", c, {SEL, GNT, VALID, TIMEOUT}, exp_vec());
      end
      if (c == 2) begin
        vectors++;
        if ({SEL, GNT, VALID, TIMEOUT} !== 8'h00) begin
          miscompares++;
          $display("FAIL rst_mid: got %h expected 00", {SEL, GNT, VALID, TIMEOUT});
        end
      end
      if (c == 3) begin
        vectors++;
        if ({SEL, GNT} !== {2'b00, 4'b0001}) begin
          miscompares++;
          $display("FAIL rst_regrant: got sel=%b gnt=%b expected sel=00 gnt=0001", SEL, GNT);
        end
      end
    end
    RST = 1'b0; REQ = 4'b0000;
  endtask

  task automatic test_random();
    RST = 1'b1; tick(); RST = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) REQ = 4'($urandom);
      DONE = ($urandom_range(0, 9) == 0);
      RST  = ($urandom_range(0, 99) == 0);
      tick();
      vectors++;
      if ({SEL, GNT, VALID, TIMEOUT} !== exp_vec()) begin
        miscompares++;
        $display("FAIL rand_model c%0d: got %h expected %h", c, {SEL, GNT, VALID, TIMEOUT}, exp_vec());
      end
    end
    RST = 1'b0; DONE = 1'b0; REQ = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_done_in_idle();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_done_at_limit();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mux_select_arbiter.md
# mux_select_arbiter

Round-robin arbiter that shares one 32-bit, four-input datapath resource among four requesters. It drives the 2-bit select of the shared 4:1 mux and a one-hot grant back to the requesters. Each grant is held until the shared resource signals completion, the requester withdraws, or a hold-time limit expires. It sits between the requesting units and the shared mux/resource pair.

## Interface
- MAX_HOLD, default 16: maximum cycles one grant may stay active before forced release; legal range 2..255.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  4  request vector; bit i = requester i wants the resource; level-sensitive.
- DONE  in  1  shared resource completed the current transaction; single-cycle pulse.
- SEL  out  2  select to the shared 4:1 mux; index of the current or most recent grantee.
- GNT  out  4  one-hot grant; all zero when no grant is active.
- VALID  out  1  high while a grant is active; start/qualify for the shared resource.
- TIMEOUT  out  1  one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- State machine: IDLE, GRANT, RELEASE.
- IDLE:
  - If REQ is nonzero, choose the winner by round-robin, searching from index (last+1) mod 4 upward with wrap.
  - Register SEL = winner and GNT = one-hot(winner), set VALID = 1, clear the hold counter, and go to GRANT.
  - If REQ is zero, stay in IDLE; SEL holds its last value.
- GRANT: the hold counter increments every cycle. Exit conditions, in priority order:
  - DONE = 1: go to RELEASE.
  - REQ[SEL] = 0 (requester withdrew): go to RELEASE.
  - Counter = MAX_HOLD-1: go to RELEASE and pulse TIMEOUT.
- RELEASE:
  - GNT = 0 and VALID = 0; SEL unchanged; last = SEL.
  - Always return to IDLE next cycle. This is a mandatory one-cycle bus turnaround.
- Round-robin pointer `last` is updated only on release, so a requester that has just been served has lowest priority next time.
- DONE is ignored in IDLE and RELEASE.
- REQ changes during GRANT on non-granted bits have no effect until the next IDLE evaluation.
- The hold counter width is clog2(MAX_HOLD)+1 bits and saturates; it never wraps.

## Timing
- Reset values: SEL = 2'b00, GNT = 4'b0000, VALID = 0, TIMEOUT = 0, state = IDLE, last = 3 (requester 0 has highest priority after reset), counter = 0.
- RST asserted in any state, including mid-grant, forces the reset values at that edge. No TIMEOUT is produced by a reset.
- Grant latency: REQ sampled high in IDLE at edge t gives GNT/VALID/SEL valid from edge t+1.
- Release latency: DONE high at edge t in GRANT gives GNT = 0 from edge t+1 (RELEASE), IDLE at t+2, and the next grant visible at t+3.
- Back-to-back throughput is limited by turnaround: minimum 3 cycles between grant starts.
- Timeout: a grant starting at edge g with no DONE and no withdrawal has GNT active for exactly MAX_HOLD cycles. TIMEOUT is high for the single cycle in which GNT first reads 0.
- Simultaneous DONE and timeout: DONE wins and TIMEOUT stays 0.
- Simultaneous DONE and withdrawal: normal release, no TIMEOUT.
- GNT is always one-hot or zero. VALID always equals |GNT. While VALID = 1, SEL always equals the index of GNT.

## Test plan
- Reset then REQ = 4'b1111 with DONE two cycles after each grant -> grant order 0,1,2,3,0. Each GNT is held 2 cycles, and each grant start is 4 cycles after the previous one.
- REQ = 4'b0100 only; DONE never asserted; MAX_HOLD = 16 -> GNT = 4'b0100 for exactly 16 cycles, then TIMEOUT = 1 for one cycle, then regrant to 2 at 2 cycles after release.
- Requester 1 granted, REQ[1] dropped on the 3rd grant cycle -> GNT = 0 next cycle, no TIMEOUT, SEL stays 2'b01; with REQ = 4'b1010 still pending, the next grant goes to 3.
- DONE asserted on the same edge the counter reaches MAX_HOLD-1 -> release with TIMEOUT = 0.
- RST pulsed mid-grant to requester 2 -> next cycle SEL = 0, GNT = 0, VALID = 0; with REQ = 4'b0101 the following grant goes to 0, not 2.
- DONE pulses while in IDLE with REQ = 0 -> no state change, all outputs stay at reset values.
